// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stalls, taken-branch flushes, data-memory freezes.
// Optional HAZARD_PERF_CNT_EN adds stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_idex_memRead,
    input  logic [REG_AW-1:0] i_idex_rt,
    input  logic [REG_AW-1:0] i_ifid_rs,
    input  logic [REG_AW-1:0] i_ifid_rt,
    input  logic              i_ifid_uses_rt,
    input  logic              i_branch_taken,
    input  logic              i_mem_busy,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_ifid_flush,
    output logic              o_idex_write,
    output logic              o_idex_bubble,
    output logic              o_exmem_write,
    output logic              o_exmem_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       o_stall_cycles,
    output logic [31:0]       o_flush_events,
`endif
    output logic              o_mem_timeout
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FCW-1:0] FCNT_ZERO    = FCW'(0);
    localparam logic [FCW-1:0] FCNT_ONE     = FCW'(1);
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [WCW-1:0] WCNT_ZERO    = WCW'(0);
    localparam logic [WCW-1:0] WCNT_ONE     = WCW'(1);
    localparam logic [WCW-1:0] WAIT_MAX     = WCW'(MEM_TIMEOUT);
    localparam bit             MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t         r_state;
    logic [FCW-1:0] r_flush_cnt;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_mem_timeout;
    logic           w_in_flush;
    logic           w_load_use;
    logic           w_branch_go;

    // A freeze leaves flush_cnt untouched, so a non-zero count in MEM_WAIT means FLUSH was interrupted.
    assign w_in_flush  = (r_state == S_FLUSH) ||
                         ((r_state == S_MEM_WAIT) && (r_flush_cnt != FCNT_ZERO));
    assign w_load_use  = i_idex_memRead && (i_idex_rt != {REG_AW{1'b0}}) &&
                         ((i_idex_rt == i_ifid_rs) || (i_ifid_uses_rt && (i_idex_rt == i_ifid_rt)));
    assign w_branch_go = !i_reset && !i_mem_busy && i_branch_taken;
    assign o_mem_timeout = r_mem_timeout;

    // Same-cycle pipeline-register controls, resolved in priority order.
    always_comb begin
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_write  = 1'b1;
        o_idex_bubble = 1'b0;
        o_exmem_write = 1'b1;
        o_exmem_flush = 1'b0;
        if (i_reset) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_write  = 1'b0;
            o_exmem_write = 1'b0;
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            o_exmem_flush = 1'b1;
        end else if (i_mem_busy) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_write  = 1'b0;
            o_exmem_write = 1'b0;
        end else if (i_branch_taken) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            o_exmem_flush = 1'b1;
        end else if (w_in_flush) begin
            o_ifid_flush  = 1'b1;
        end else if (w_load_use) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
        end else begin
            o_pc_write    = 1'b1;
        end
    end

    // State, flush/wait counters and the sticky timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_RUN;
            r_flush_cnt   <= FCNT_ZERO;
            r_wait_cnt    <= WCNT_ZERO;
            r_mem_timeout <= 1'b0;
        end else if (i_mem_busy) begin
            r_state <= S_MEM_WAIT;
            if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + WCNT_ONE;
            end else begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_wait_cnt <= WCNT_ZERO;
            if (i_branch_taken) begin
                if (MULTI_FLUSH) begin
                    r_state     <= S_FLUSH;
                    r_flush_cnt <= FLUSH_RELOAD;
                end else begin
                    r_state     <= S_RUN;
                    r_flush_cnt <= FCNT_ZERO;
                end
            end else if (w_in_flush) begin
                r_flush_cnt <= r_flush_cnt - FCNT_ONE;
                r_state     <= (r_flush_cnt == FCNT_ONE) ? S_RUN : S_FLUSH;
            end else begin
                r_state <= S_RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;

    // Free-running wrap-around counters of PC stall cycles and accepted branch flushes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_events <= 32'd0;
        end else begin
            r_stall_cycles <= r_stall_cycles + {31'd0, !o_pc_write};
            r_flush_events <= r_flush_events + {31'd0, w_branch_go};
        end
    end
`else
    logic w_unused_branch_go;
    assign w_unused_branch_go = w_branch_go;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, MEM_TIMEOUT=15) with an expected-value queue.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mr = 1'b0;
    logic [4:0] xrt = 5'd0;
    logic [4:0] rs = 5'd0;
    logic [4:0] irt = 5'd0;
    logic       ut = 1'b0;
    logic       bt = 1'b0;
    logic       mb = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic       exmem_write, exmem_flush, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    logic [7:0] sb[$];

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, exmem_flush}
    localparam logic [6:0] DEF   = 7'b1101010;
    localparam logic [6:0] RSTV  = 7'b0010101;
    localparam logic [6:0] STALL = 7'b0001110;
    localparam logic [6:0] FRZ   = 7'b0000000;
    localparam logic [6:0] BR    = 7'b1111111;
    localparam logic [6:0] FL    = 7'b1111010;

    pipeline_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(3), .MEM_TIMEOUT(15)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_idex_memRead (mr),
        .i_idex_rt      (xrt),
        .i_ifid_rs      (rs),
        .i_ifid_rt      (irt),
        .i_ifid_uses_rt (ut),
        .i_branch_taken (bt),
        .i_mem_busy     (mb),
        .o_pc_write     (pc_write),
        .o_ifid_write   (ifid_write),
        .o_ifid_flush   (ifid_flush),
        .o_idex_write   (idex_write),
        .o_idex_bubble  (idex_bubble),
        .o_exmem_write  (exmem_write),
        .o_exmem_flush  (exmem_flush),
`ifdef HAZARD_PERF_CNT_EN
        .o_stall_cycles (stall_cycles),
        .o_flush_events (flush_events),
`endif
        .o_mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic rst, input logic m, input logic [4:0] a_xrt,
                        input logic [4:0] a_rs, input logic [4:0] a_irt, input logic u,
                        input logic b, input logic busy, input logic [6:0] ctl, input logic to);
        logic [7:0] obs;
        logic [7:0] exp_v;
        @(posedge clk);
        #1;
        reset = rst; mr = m; xrt = a_xrt; rs = a_rs; irt = a_irt; ut = u; bt = b; mb = busy;
        sb.push_back({ctl, to});
        @(negedge clk);
        obs   = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                 exmem_write, exmem_flush, mem_timeout};
        exp_v = sb.pop_front();
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic idle(input string tag, input logic [6:0] ctl, input logic to);
        step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, to);
    endtask

    task automatic brn(input string tag, input logic [6:0] ctl, input logic to);
        step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, ctl, to);
    endtask

    task automatic busy(input string tag, input logic b, input logic to);
        step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, b, 1'b1, FRZ, to);
    endtask

    initial begin
        step("reset0", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RSTV, 1'b0);
        step("reset1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RSTV, 1'b0);
        idle("idle", DEF, 1'b0);
        // lw $2 in EX, add $3,$2,$4 in ID
        step("lu_rs",      1'b0, 1'b1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, STALL, 1'b0);
        step("lu_release", 1'b0, 1'b0, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, DEF, 1'b0);
        step("lu_rt",      1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, STALL, 1'b0);
        step("lu_rt_nouse",1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, DEF, 1'b0);
        step("lu_r0",      1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, DEF, 1'b0);
        step("lu_noload",  1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, DEF, 1'b0);
        // taken branch, three-cycle flush
        brn("br0", BR, 1'b0);
        idle("br_fl1", FL, 1'b0);
        idle("br_fl2", FL, 1'b0);
        idle("br_done", DEF, 1'b0);
        // load-use inside FLUSH suppressed
        brn("br_lu0", BR, 1'b0);
        step("br_lu_sup", 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, FL, 1'b0);
        idle("br_lu_fl2", FL, 1'b0);
        idle("br_lu_done", DEF, 1'b0);
        // re-branch during FLUSH restarts the sequence
        brn("rb0", BR, 1'b0);
        idle("rb_fl1", FL, 1'b0);
        brn("rb_restart", BR, 1'b0);
        idle("rb_fl_a", FL, 1'b0);
        idle("rb_fl_b", FL, 1'b0);
        idle("rb_done", DEF, 1'b0);
        // freeze in the middle of FLUSH keeps progress
        brn("fz_br", BR, 1'b0);
        idle("fz_fl1", FL, 1'b0);
        busy("fz_frozen", 1'b0, 1'b0);
        idle("fz_fl2", FL, 1'b0);
        idle("fz_done", DEF, 1'b0);
        // branch held during 4 busy cycles waits
        for (int i = 0; i < 4; i++) busy("mw_br_frozen", 1'b1, 1'b0);
        brn("mw_br_go", BR, 1'b0);
        idle("mw_fl1", FL, 1'b0);
        idle("mw_fl2", FL, 1'b0);
        idle("mw_done", DEF, 1'b0);
        // exactly MEM_TIMEOUT busy cycles: no timeout
        for (int i = 0; i < 15; i++) busy("to15_busy", 1'b0, 1'b0);
        idle("to15_release", DEF, 1'b0);
        // MEM_TIMEOUT+1 busy cycles: sticky timeout
        for (int i = 0; i < 16; i++) busy("to16_busy", 1'b0, 1'b0);
        idle("to16_sticky0", DEF, 1'b1);
        step("to16_lu", 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, STALL, 1'b1);
        idle("to16_sticky1", DEF, 1'b1);
        // reset while in FLUSH with two cycles left
        brn("rf_br", BR, 1'b1);
        step("rf_reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RSTV, 1'b1);
        idle("rf_run", DEF, 1'b0);
        idle("rf_run2", DEF, 1'b0);
        // reset while in MEM_WAIT
        busy("rm_busy", 1'b0, 1'b0);
        step("rm_reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RSTV, 1'b0);
        idle("rm_run", DEF, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        assert ({stall_cycles, flush_events} === 64'd0) else begin
            n_fails++;
            $error("FAIL perf_reset: observed %0d/%0d expected 0/0", stall_cycles, flush_events);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
